// File: rtl/pixel_row_loader.sv
// Collects 8 raster-order pixels, level-shifts them to signed samples and presents them as one row.
// Optional macro ROW_COUNT_EN adds a 3-bit row counter driving out_last_row.
module pixel_row_loader #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic        [WIDTH-1:0] in_pixel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [WIDTH-1:0] out_pixel_0,
   output logic signed [WIDTH-1:0] out_pixel_1,
   output logic signed [WIDTH-1:0] out_pixel_2,
   output logic signed [WIDTH-1:0] out_pixel_3,
   output logic signed [WIDTH-1:0] out_pixel_4,
   output logic signed [WIDTH-1:0] out_pixel_5,
   output logic signed [WIDTH-1:0] out_pixel_6,
   output logic signed [WIDTH-1:0] out_pixel_7,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last_row,
   output logic        [3:0]       dbg_count
);

   // Handshakes: a pixel moves when in_valid && in_ready on a rising edge; a row moves
   // when out_valid && out_ready. in_ready depends only on state; out_pixel_* hold while
   // out_valid && !out_ready.

   logic        [3:0]       count_q;
   logic signed [WIDTH-1:0] slot_q [7];
   logic signed [WIDTH-1:0] pend_q;
   logic signed [WIDTH-1:0] row_q  [8];
   logic                    valid_q;
   logic signed [WIDTH-1:0] shifted;
   logic                    accept;
   logic                    out_free;
   logic                    xfer;

   // Subtracting 2^(WIDTH-1) from an unsigned value is just an MSB flip.
   assign shifted  = {~in_pixel[WIDTH-1], in_pixel[WIDTH-2:0]};
   assign in_ready = (count_q != 4'd8);
   assign accept   = in_valid && in_ready;
   assign out_free = !valid_q || out_ready;
   assign xfer     = out_free && ((count_q == 4'd8) || (accept && count_q == 4'd7));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= 4'd0;
         valid_q <= 1'b0;
         pend_q  <= '0;
         for (int i = 0; i < 7; i++) slot_q[i] <= '0;
         for (int i = 0; i < 8; i++) row_q[i]  <= '0;
      end else begin
         if (xfer) begin
            for (int i = 0; i < 7; i++) row_q[i] <= slot_q[i];
            row_q[7] <= (count_q == 4'd8) ? pend_q : shifted;
            valid_q  <= 1'b1;
         end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
         end

         if (xfer) begin
            count_q <= 4'd0;
         end else if (accept) begin
            // 8th pixel with a busy output register parks in pend_q until the row drains.
            if (count_q == 4'd7) begin
               pend_q  <= shifted;
               count_q <= 4'd8;
            end else begin
               for (int i = 0; i < 7; i++)
                  if (count_q == 4'(i)) slot_q[i] <= shifted;
               count_q <= count_q + 4'd1;
            end
         end
      end
   end

`ifdef ROW_COUNT_EN
   logic [2:0] row_cnt_q;
   logic       last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt_q <= 3'd0;
         last_q    <= 1'b0;
      end else if (xfer) begin
         last_q    <= (row_cnt_q == 3'd7);
         row_cnt_q <= row_cnt_q + 3'd1;
      end else if (valid_q && out_ready) begin
         last_q    <= 1'b0;
      end
   end

   assign out_last_row = last_q;
`else
   assign out_last_row = 1'b0;
`endif

   assign out_valid   = valid_q;
   assign dbg_count   = count_q;
   assign out_pixel_0 = row_q[0];
   assign out_pixel_1 = row_q[1];
   assign out_pixel_2 = row_q[2];
   assign out_pixel_3 = row_q[3];
   assign out_pixel_4 = row_q[4];
   assign out_pixel_5 = row_q[5];
   assign out_pixel_6 = row_q[6];
   assign out_pixel_7 = row_q[7];

endmodule

// File: tb/tb_pixel_row_loader.sv
// Directed bench for pixel_row_loader: level shift, row handoff, backpressure, reset abort.
module tb_pixel_row_loader;

   logic              clk = 1'b0;
   logic              rst;
   logic        [7:0] in_pixel;
   logic              in_valid;
   logic              in_ready;
   logic signed [7:0] out_pixel_0, out_pixel_1, out_pixel_2, out_pixel_3;
   logic signed [7:0] out_pixel_4, out_pixel_5, out_pixel_6, out_pixel_7;
   logic              out_valid;
   logic              out_ready;
   logic              out_last_row;
   logic        [3:0] dbg_count;

`ifdef ROW_COUNT_EN
   localparam bit ROWCNT = 1'b1;
`else
   localparam bit ROWCNT = 1'b0;
`endif

   pixel_row_loader #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst),
      .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
      .out_pixel_0(out_pixel_0), .out_pixel_1(out_pixel_1),
      .out_pixel_2(out_pixel_2), .out_pixel_3(out_pixel_3),
      .out_pixel_4(out_pixel_4), .out_pixel_5(out_pixel_5),
      .out_pixel_6(out_pixel_6), .out_pixel_7(out_pixel_7),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_last_row(out_last_row), .dbg_count(dbg_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   logic [7:0] op [8];
   assign op[0] = out_pixel_0;
   assign op[1] = out_pixel_1;
   assign op[2] = out_pixel_2;
   assign op[3] = out_pixel_3;
   assign op[4] = out_pixel_4;
   assign op[5] = out_pixel_5;
   assign op[6] = out_pixel_6;
   assign op[7] = out_pixel_7;

   // scoreboard
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q [$];
   logic [7:0] hold [8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_row(input string tag);
      logic [7:0] e;
      for (int i = 0; i < 8; i++) begin
         if (exp_q.size() == 0) begin
            check($sformatf("%s_qempty[%0d]", tag, i), 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, i), {24'd0, op[i]}, {24'd0, e});
         end
      end
   endtask

   // driver tasks
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // drive one accepted pixel and record its expected level-shifted value
   task automatic send(input logic [7:0] p);
      in_valid = 1'b1;
      in_pixel = p;
      exp_q.push_back(p ^ 8'h80);
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      int tb_cnt;
      int cyc;
      rst = 1'b0; in_valid = 1'b0; in_pixel = 8'd0; out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_count", dbg_count, 0);
      check("rst_last", out_last_row, 0);
      check("rst_pix0", op[0], 0);
      tick(); tick();
      rst = 1'b0;

      // ramp 0..7 with output always ready
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(8'(k));
         check("ramp_in_ready", in_ready, 1);
      end
      check("ramp_valid", out_valid, 1);
      check_row("ramp_row");
      check("ramp_last", out_last_row, 0);
      tick();
      check("ramp_consumed", out_valid, 0);

      // 255/0 alternating extremes
      for (int k = 0; k < 8; k++) send((k % 2 == 0) ? 8'd255 : 8'd0);
      check("alt_valid", out_valid, 1);
      check_row("alt_row");
      tick();

      // 64-pixel continuous stream: one row per 8 cycles
      do_reset();
      for (int k = 0; k < 64; k++) begin
         in_valid = 1'b1;
         in_pixel = 8'(k * 37 + 5);
         exp_q.push_back(8'(k * 37 + 5) ^ 8'h80);
         tick();
         check("strm_in_ready", in_ready, 1);
         check("strm_valid", out_valid, (k % 8 == 7) ? 1 : 0);
         if (k % 8 == 7) begin
            check_row($sformatf("strm_row%0d", k / 8));
            check("strm_last", out_last_row, (ROWCNT && (k / 8 == 7)) ? 1 : 0);
         end
      end
      in_valid = 1'b0;
      tick();

      // 16 pixels of 200 against a stalled output
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 16; k++) begin
         send(8'd200);
         if (k == 7) begin
            check("bp_first_valid", out_valid, 1);
            check_row("bp_first_row");
         end
      end
      check("bp_count8", dbg_count, 8);
      check("bp_in_ready0", in_ready, 0);
      for (int i = 0; i < 8; i++) check("bp_first_hold", op[i], 8'h48);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp_xfer_valid", out_valid, 1);
      check("bp_xfer_count", dbg_count, 0);
      check("bp_xfer_in_ready", in_ready, 1);
      check_row("bp_second_row");
      check("bp_last", out_last_row, 0);

      // drain, then hold a known row while In_Valid toggles randomly
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("drain_valid", out_valid, 0);
      for (int k = 0; k < 8; k++) send(8'(10 * k));
      for (int i = 0; i < 8; i++) hold[i] = 8'(10 * i) ^ 8'h80;
      check("hold_valid", out_valid, 1);
      check_row("hold_row");
      tb_cnt = 0;
      cyc = 0;
      while (tb_cnt < 8 && cyc < 200) begin
         in_valid = ($urandom_range(0, 1) == 1);
         in_pixel = 8'($urandom_range(0, 255));
         if (in_valid) begin
            exp_q.push_back(in_pixel ^ 8'h80);
            tb_cnt++;
         end
         tick();
         check("hold_count", dbg_count, tb_cnt);
         for (int i = 0; i < 8; i++) check($sformatf("hold_stable[%0d]", i), op[i], hold[i]);
         cyc++;
      end
      check("hold_budget", tb_cnt, 8);
      in_valid = 1'b1;
      in_pixel = 8'd1;
      tick();
      in_valid = 1'b0;
      check("hold_stall_count", dbg_count, 8);
      check("hold_stall_valid", out_valid, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_xfer_valid", out_valid, 1);
      check("hold_xfer_count", dbg_count, 0);
      check_row("hold_new_row");

      // async reset mid-row with a valid row presented
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_pixel = 8'd77;
         tick();
      end
      in_valid = 1'b0;
      check("abort_count5", dbg_count, 5);
      #2 rst = 1'b1;
      #1;
      check("abort_count", dbg_count, 0);
      check("abort_valid", out_valid, 0);
      check("abort_last", out_last_row, 0);
      for (int i = 0; i < 8; i++) check("abort_pix", op[i], 0);
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         send(8'd128);
         if (k < 7) check("abort_no_early", out_valid, 0);
      end
      check("abort_row_valid", out_valid, 1);
      check_row("abort_row");
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
